// File: rtl/mem_arb_if.sv
// Bus bundle shared by the arbiter's two master ports and its slave-side port.
// The master modport is the requester side; slave is the responder side.
interface mem_arb_if;
  logic [31:0] addr;
  logic        stb;
  logic [3:0]  we;
  logic [31:0] dat_w;
  logic        ack;
  logic        err;
  logic [31:0] dat_r;

  modport master (output addr, stb, we, dat_w, input ack, err, dat_r);
  modport slave  (input addr, stb, we, dat_w, output ack, err, dat_r);
endinterface

// File: rtl/mem_arb.sv
// Two-master arbiter (M0 ifetch, M1 load/store) in front of the vma port, with timeout abort.
// Define ARB_RR_EN for round-robin arbitration; otherwise M1 has fixed priority.
module mem_arb #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CW      = 11
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  m0,
  mem_arb_if.slave  m1,
  mem_arb_if.master s
);

  typedef enum logic [1:0] {StIdle, StBusy0, StBusy1} state_e;

  localparam logic [CW-1:0] TmoLast = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant1;
  logic          tmo_hit;
  logic          unused_in;

  assign tmo_hit   = (TIMEOUT != 0) && (cnt_q == TmoLast);
  assign m0.dat_r  = s.dat_r;
  assign m1.dat_r  = s.dat_r;
  assign unused_in = ^{m0.we, m0.dat_w, s.err};

`ifdef ARB_RR_EN
  logic last_q, last_d;

  // On a tie the master that was not granted last wins.
  always_comb begin
    if (m0.stb && m1.stb) grant1 = ~last_q;
    else                  grant1 = m1.stb;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == StIdle && (m0.stb || m1.stb)) last_d = grant1;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  assign grant1 = m1.stb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s.stb   = 1'b0;
    s.addr  = '0;
    s.we    = '0;
    s.dat_w = '0;
    m0.ack  = 1'b0;
    m0.err  = 1'b0;
    m1.ack  = 1'b0;
    m1.err  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (m0.stb || m1.stb) state_d = grant1 ? StBusy1 : StBusy0;
      end
      StBusy0: begin
        s.stb  = m0.stb;
        s.addr = m0.addr;
        if (s.ack) begin
          m0.ack  = 1'b1;
          state_d = StIdle;
        end else if (!m0.stb) begin
          state_d = StIdle;
        end else if (tmo_hit) begin
          m0.err  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBusy1: begin
        s.stb   = m1.stb;
        s.addr  = m1.addr;
        s.we    = m1.we;
        s.dat_w = m1.dat_w;
        if (s.ack) begin
          m1.ack  = 1'b1;
          state_d = StIdle;
        end else if (!m1.stb) begin
          state_d = StIdle;
        end else if (tmo_hit) begin
          m1.err  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // A reset cycle abandons the transaction silently.
    if (rst) begin
      m0.ack = 1'b0;
      m0.err = 1'b0;
      m1.ack = 1'b0;
      m1.err = 1'b0;
    end
  end

endmodule
